modulator: RTL and testbench

MODULATOR -- requirements
Module: modulator

---
 rtl/modulator_if.sv | 13 +
 rtl/modulator.sv | 146 ++++++++++++++
 tb/tb_modulator.sv | 237 +++++++++++++++++++++++
 3 files changed

// File: rtl/modulator_if.sv
// FIFO-side handshake of the PSK modulator: first-word-fall-through head data,
// empty flag and a one-clock pop strobe driven by the modulator.
`timescale 1ns/1ps
interface modulator_if;
  logic [7:0] sample;
  logic       empty;
  logic       read;

  // Modulator side: consumes head data, issues pops.
  modport master (input sample, input empty, output read);
  // FIFO side: presents head data, receives pops.
  modport slave  (output sample, output empty, input read);
endinterface

// File: rtl/modulator.sv
// PSK modulator: pops one B-bit symbol from a FWFT FIFO, then emits R carrier
// periods of a square wave whose phase is shifted by (sym*P) >> B clocks,
// along with a phase-0 reference carrier, a symbol clock and a sync marker.
`timescale 1ns/1ps
module modulator #(
  parameter int PARAMETER01 = 10, // carrier period in clocks, >= 2
  parameter int PARAMETER02 = 4,  // symbol width B, 1..8
  parameter int PARAMETER03 = 0,  // reserved, no functional effect
  parameter int PARAMETER04 = 5   // carrier periods per symbol R, >= 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  modulator_if.master      fifo,
  output logic             nsync,
  output logic             bclk,
  output logic             pwm,
  output logic             symb_clk
);

  localparam int P   = PARAMETER01;
  localparam int B   = PARAMETER02;
  localparam int R   = PARAMETER04;
  localparam int T   = P * R;
  localparam int H   = P / 2;
  localparam int K_W = $clog2(P);
  localparam int R_W = (R > 1) ? $clog2(R) : 1;

  // Reserved parameter is carried but deliberately has no effect.
  localparam int reserved_unused = PARAMETER03;

  typedef enum logic [1:0] {IDLE, LOAD, TX} state_t;

  state_t           state, state_nx;
  logic [K_W-1:0]   k, k_nx;
  logic [R_W-1:0]   rep, rep_nx;
  logic [B-1:0]     sym, sym_nx;

  logic             pwm_p0, bclk_p0, symb_p0, nsync_p0;

  // Only sample[B-1:0] carries symbol data; the upper bits are ignored.
  logic             sample_unused;
  assign sample_unused = ^fifo.sample;

  // Phase offset in clocks; sym < 2^B guarantees the result is below P.
  function automatic int phase_off(input logic [B-1:0] s);
    int sv;
    sv = int'(s);
    return (sv * P) >> B;
  endfunction

  // Shifted carrier level at carrier position kk for symbol s.
  function automatic logic pwm_level(input logic [K_W-1:0] kk, input logic [B-1:0] s);
    int ph;
    ph = int'(kk) + phase_off(s);
    if (ph >= P) ph = ph - P;
    return ph < H;
  endfunction

  // Symbol clock is high for the first half of the T-clock symbol.
  function automatic logic symb_level(input logic [K_W-1:0] kk, input logic [R_W-1:0] rr);
    int pos;
    pos = int'(rr) * P + int'(kk);
    return pos < (T / 2);
  endfunction

  // State and counter register; reset discards any symbol in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      k     <= '0;
      rep   <= '0;
      sym   <= '0;
    end else begin
      state <= state_nx;
      k     <= k_nx;
      rep   <= rep_nx;
      sym   <= sym_nx;
    end
  end

  // Next state: one LOAD clock per symbol, then exactly T clocks of TX.
  always_comb begin
    state_nx = state;
    k_nx     = k;
    rep_nx   = rep;
    sym_nx   = sym;
    unique case (state)
      IDLE: begin
        if (enable && !fifo.empty) state_nx = LOAD;
      end
      LOAD: begin
        state_nx = TX;
        sym_nx   = fifo.sample[B-1:0];
        k_nx     = '0;
        rep_nx   = '0;
      end
      TX: begin
        if (k == K_W'(P - 1)) begin
          k_nx = '0;
          if (rep == R_W'(R - 1)) begin
            rep_nx   = '0;
            state_nx = (enable && !fifo.empty) ? LOAD : IDLE;
          end else begin
            rep_nx = rep + R_W'(1);
          end
        end else begin
          k_nx = k + K_W'(1);
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // Outputs: pop strobe decoded from state; carrier levels computed from the
  // next-state values so the registered outputs line up with the TX clocks.
  always_comb begin
    fifo.read = (state == LOAD);
    pwm_p0    = 1'b0;
    bclk_p0   = 1'b0;
    symb_p0   = 1'b0;
    nsync_p0  = 1'b1;
    if (state_nx == TX) begin
      pwm_p0   = pwm_level(k_nx, sym_nx);
      bclk_p0  = (int'(k_nx) < H);
      symb_p0  = symb_level(k_nx, rep_nx);
      nsync_p0 = !((k_nx == '0) && (rep_nx == '0));
    end
  end

  // Output register stage.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pwm      <= 1'b0;
      bclk     <= 1'b0;
      symb_clk <= 1'b0;
      nsync    <= 1'b1;
    end else begin
      pwm      <= pwm_p0;
      bclk     <= bclk_p0;
      symb_clk <= symb_p0;
      nsync    <= nsync_p0;
    end
  end

endmodule

// File: tb/tb_modulator.sv
// Bench for the PSK modulator: a table of symbols with hand-derived phase
// offsets and carrier patterns, a scoreboard queue of expected symbols, and
// hand-written sequences for mid-symbol changes, FIFO underrun and reset.
`timescale 1ns/1ps
module tb_modulator;
  localparam int P = 10;
  localparam int B = 4;
  localparam int R = 5;
  localparam int T = P * R;
  localparam logic [9:0] BCLK_MASK = 10'h01F;

  typedef struct {
    logic [7:0] sample;
    int         off;
    logic [9:0] pwm_mask;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic enable = 1'b0;
  logic nsync, bclk, pwm, symb_clk;
  int   cyc = 0;
  int   n_tests = 0;
  int   n_fail = 0;
  int   t_read;
  vec_t tbl[6];
  vec_t sb[$];

  modulator_if fifo ();

  modulator #(
    .PARAMETER01(P),
    .PARAMETER02(B),
    .PARAMETER03(0),
    .PARAMETER04(R)
  ) dut (
    .clk(clk),
    .rst(rst),
    .enable(enable),
    .fifo(fifo),
    .nsync(nsync),
    .bclk(bclk),
    .pwm(pwm),
    .symb_clk(symb_clk)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Offset recovered from the observed pattern: the rising position kr obeys
  // (kr + off) mod P == 0.
  function automatic int meas_off(input logic [9:0] m);
    for (int kk = 0; kk < P; kk++)
      if (m[kk] && !m[(kk + P - 1) % P]) return (P - kk) % P;
    return -1;
  endfunction

  // Called at the negedge of a LOAD clock; walks the T TX clocks.
  task automatic capture(input int chg_at, input logic [7:0] chg_val,
                         input int empty_at, input int enoff_at,
                         output logic [9:0] pm, output logic [9:0] bm,
                         output int rep_err, output int ns_err,
                         output int sc_err, output int rd_err);
    pm = '0; bm = '0; rep_err = 0; ns_err = 0; sc_err = 0; rd_err = 0;
    for (int i = 0; i < T; i++) begin
      @(negedge clk);
      if (i == chg_at) fifo.sample = chg_val;
      if (i == empty_at) fifo.empty = 1'b1;
      if (i == enoff_at) enable = 1'b0;
      if (i < P) begin
        pm[i] = pwm;
        bm[i] = bclk;
      end else if (pwm !== pm[i % P] || bclk !== bm[i % P]) begin
        rep_err++;
      end
      if (nsync !== ((i == 0) ? 1'b0 : 1'b1)) ns_err++;
      if (symb_clk !== ((i < T / 2) ? 1'b1 : 1'b0)) sc_err++;
      if (fifo.read !== 1'b0) rd_err++;
    end
  endtask

  task automatic run_symbol(input string tag, input int chg_at, input logic [7:0] chg_val,
                            input int empty_at, input int enoff_at);
    vec_t e;
    logic [9:0] pm, bm;
    int re, ne, se, de;
    capture(chg_at, chg_val, empty_at, enoff_at, pm, bm, re, ne, se, de);
    if (sb.size() == 0) begin
      check({tag, " scoreboard_entry"}, 0, 1);
      return;
    end
    e = sb.pop_front();
    check({tag, " offset"}, meas_off(pm), e.off);
    check({tag, " pwm_pattern"}, int'(pm), int'(e.pwm_mask));
    check({tag, " bclk_pattern"}, int'(bm), int'(BCLK_MASK));
    check({tag, " periods_consistent"}, re, 0);
    check({tag, " nsync_first_only"}, ne, 0);
    check({tag, " symb_clk_half"}, se, 0);
    check({tag, " no_read_in_tx"}, de, 0);
  endtask

  task automatic wait_read(input string tag, input int budget);
    int n;
    n = 0;
    while (fifo.read !== 1'b1 && n < budget) begin
      @(negedge clk);
      n++;
    end
    check({tag, " read_seen"}, int'(fifo.read === 1'b1), 1);
  endtask

  task automatic check_idle(input string tag, input int ncyc);
    int reads, bad;
    reads = 0; bad = 0;
    repeat (ncyc) begin
      @(negedge clk);
      if (fifo.read !== 1'b0) reads++;
      if (pwm !== 1'b0 || bclk !== 1'b0 || symb_clk !== 1'b0 || nsync !== 1'b1) bad++;
    end
    check({tag, " reads"}, reads, 0);
    check({tag, " idle_outputs"}, bad, 0);
  endtask

  task automatic check_reset_outs(input string tag);
    check({tag, " read"}, int'(fifo.read), 0);
    check({tag, " nsync"}, int'(nsync), 1);
    check({tag, " pwm"}, int'(pwm), 0);
    check({tag, " bclk"}, int'(bclk), 0);
    check({tag, " symb_clk"}, int'(symb_clk), 0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0] = '{8'h03, 1, 10'h20F};
    tbl[1] = '{8'h0C, 7, 10'h0F8};
    tbl[2] = '{8'h06, 3, 10'h383};
    tbl[3] = '{8'h09, 5, 10'h3E0};
    tbl[4] = '{8'h00, 0, 10'h01F};
    tbl[5] = '{8'h0F, 9, 10'h03E};

    // Held in reset with a pending sample.
    rst = 1'b0;
    enable = 1'b1;
    fifo.empty = 1'b0;
    fifo.sample = tbl[0].sample;
    repeat (3) @(negedge clk);
    check_reset_outs("reset_hold");

    sb.push_back(tbl[0]);
    rst = 1'b1;
    #1;
    check("no_read_before_edge", int'(fifo.read), 0);
    wait_read("first", 5);
    t_read = cyc;

    // Table stream: back-to-back symbols, next head presented during TX.
    for (int i = 0; i < 6; i++) begin
      if (i < 5) begin
        run_symbol($sformatf("vec%0d", i), 0, tbl[i + 1].sample, -1, -1);
        sb.push_back(tbl[i + 1]);
        @(negedge clk);
        check($sformatf("vec%0d next_load", i), int'(fifo.read), 1);
        check($sformatf("vec%0d read_spacing", i), cyc - t_read, T + 1);
        t_read = cyc;
      end else begin
        run_symbol($sformatf("vec%0d", i), -1, 8'h00, -1, 0);
      end
    end

    // enable dropped during the last symbol: completes, then stays idle.
    check_idle("enable_low", 60);

    // Sample changes mid-symbol: old phase continues, new value at next LOAD.
    fifo.sample = tbl[0].sample;
    sb.push_back(tbl[0]);
    enable = 1'b1;
    wait_read("midchg", 5);
    run_symbol("midchg_old", T / 2, tbl[1].sample, -1, -1);
    sb.push_back(tbl[1]);
    @(negedge clk);
    check("midchg next_load", int'(fifo.read), 1);

    // FIFO runs dry during TX: symbol finishes, then idles until refilled.
    run_symbol("midchg_new", -1, 8'h00, 10, -1);
    check_idle("empty_hold", 40);
    fifo.sample = tbl[0].sample;
    fifo.empty = 1'b0;
    @(negedge clk);
    check("empty_release read", int'(fifo.read), 1);

    // Reset during the first TX clock of a symbol.
    @(negedge clk);
    check("pre_reset nsync", int'(nsync), 0);
    check("pre_reset pwm", int'(pwm), 1);
    #2 rst = 1'b0;
    #1;
    check_reset_outs("reset_tx");
    sb.delete();

    // Reset during LOAD forces read low at once.
    @(negedge clk);
    fifo.sample = tbl[2].sample;
    rst = 1'b1;
    #1;
    check("release read", int'(fifo.read), 0);
    @(negedge clk);
    check("rst_load read_before", int'(fifo.read), 1);
    #2 rst = 1'b0;
    #1;
    check_reset_outs("reset_load");

    // After reset the discarded symbol is not resent; new head goes out.
    @(negedge clk);
    rst = 1'b1;
    sb.push_back(tbl[2]);
    wait_read("after_rst", 5);
    run_symbol("after_rst", -1, 8'h00, -1, 0);
    check_idle("final_idle", 20);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
